// File: rtl/stopwatch_bcd_counter.sv
// Four-digit BCD stopwatch with debounced start/stop, clear and lap buttons.
// Optional lap-hold display freeze is enabled by defining STOPWATCH_LAP_HOLD_EN.
module stopwatch_bcd_counter #(
  parameter int DB_CYCLES = 1000000,
  parameter int WRAP      = 1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        tick,
  input  logic        btn_ss,
  input  logic        btn_rst,
  input  logic        btn_lap,
  output logic [15:0] digits,
  output logic [3:0]  blank,
  output logic        running,
  output logic        wrap
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);
`ifdef STOPWATCH_LAP_HOLD_EN
  localparam logic LAP_EN = 1'b1;
`else
  localparam logic LAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_e;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (c) begin
        if (v[4*k +: 4] == 4'd9) begin
          r[4*k +: 4] = 4'd0;
        end else begin
          r[4*k +: 4] = v[4*k +: 4] + 4'd1;
          c = 1'b0;
        end
      end else begin
        r[4*k +: 4] = v[4*k +: 4];
      end
    end
    return r;
  endfunction

  function automatic logic [3:0] blank_of(input logic [15:0] v);
    logic [3:0] b;
    b[3] = (v[15:12] == 4'd0);
    b[2] = b[3] && (v[11:8] == 4'd0);
    b[1] = b[2] && (v[7:4] == 4'd0);
    b[0] = 1'b0;
    return b;
  endfunction

  logic [2:0]    btn_raw;
  logic [2:0]    sync1_q, sync1_d, sync2_q, sync2_d;
  logic [2:0]    stable_q, stable_d, press_q, press_d;
  logic [CW-1:0] db_cnt_q [3];
  logic [CW-1:0] db_cnt_d [3];

  state_e        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d, digits_q, digits_d;
  logic [3:0]    blank_q, blank_d;
  logic          running_q, running_d, wrap_q, wrap_d;
  logic          hold_q, hold_d, hold_t;
  logic          ss_press, rst_press, lap_press;

  assign btn_raw   = {btn_lap, btn_rst, btn_ss};
  assign ss_press  = press_q[0];
  assign rst_press = press_q[1];
  assign lap_press = press_q[2];

  // Synchronize and debounce each button; press pulses on accepted rising levels only.
  always_comb begin
    sync1_d  = btn_raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    press_d  = 3'b000;
    for (int i = 0; i < 3; i++) begin
      db_cnt_d[i] = {CW{1'b0}};
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          stable_d[i] = sync2_q[i];
          press_d[i]  = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + CW'(1'b1);
        end
      end else begin
        db_cnt_d[i] = {CW{1'b0}};
      end
    end
  end

  // Start/pause/clear FSM, BCD count, and display/hold selection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    hold_t  = hold_q;
    case (state_q)
      IDLE: begin
        cnt_d = 16'h0000;
        if (ss_press) state_d = RUN;
        else          state_d = IDLE;
      end
      RUN: begin
        if (tick) begin
          if (cnt_q == 16'h9999) begin
            wrap_d = 1'b1;
            cnt_d  = (WRAP != 0) ? 16'h0000 : 16'h9999;
          end else begin
            cnt_d = bcd_inc(cnt_q);
          end
        end else begin
          cnt_d = cnt_q;
        end
        if (ss_press) state_d = PAUSE;
        else          state_d = RUN;
        if (lap_press && LAP_EN) hold_t = ~hold_q;
        else                     hold_t = hold_q;
      end
      PAUSE: begin
        if (ss_press) begin
          state_d = RUN;
        end else if (rst_press) begin
          state_d = IDLE;
          cnt_d   = 16'h0000;
        end else begin
          state_d = PAUSE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 16'h0000;
      end
    endcase
    hold_d    = (state_d == IDLE) ? 1'b0 : hold_t;
    digits_d  = hold_d ? digits_q : cnt_d;
    blank_d   = hold_d ? blank_q : blank_of(cnt_d);
    running_d = (state_d == RUN);
  end

  // State registers; clr dominates every other input.
  always_ff @(posedge clk) begin
    if (clr) begin
      sync1_q   <= 3'b000;
      sync2_q   <= 3'b000;
      stable_q  <= 3'b000;
      press_q   <= 3'b000;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= {CW{1'b0}};
      state_q   <= IDLE;
      cnt_q     <= 16'h0000;
      digits_q  <= 16'h0000;
      blank_q   <= 4'b1110;
      running_q <= 1'b0;
      wrap_q    <= 1'b0;
      hold_q    <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      stable_q  <= stable_d;
      press_q   <= press_d;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= db_cnt_d[i];
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      digits_q  <= digits_d;
      blank_q   <= blank_d;
      running_q <= running_d;
      wrap_q    <= wrap_d;
      hold_q    <= hold_d;
    end
  end

  assign digits  = digits_q;
  assign blank   = blank_q;
  assign running = running_q;
  assign wrap    = wrap_q;

endmodule
